// File: rtl/convolutor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : convolutor_pkg
// Description : Shared types and default geometry for the convolution
//               coprocessor Z-result path. It defines the Z streamer state
//               encoding and the Z buffer sizes that follow from the default
//               Y address and sample widths.
// Revision    : 1.0 - initial release
// ============================================================================
package convolutor_pkg;

   // Default geometry of the convolutor: Y address width and sample width.
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_DATA_WIDTH = 8;

   // Z results are full-precision products, addressed over twice the Y range.
   localparam int Z_ADDR_WIDTH = DEF_ADDR_WIDTH + 1;
   localparam int Z_DATA_WIDTH = 2 * DEF_DATA_WIDTH;
   localparam int Z_DEPTH      = 2 ** Z_ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FETCH   = 2'd2,
      STREAM  = 2'd3
   } z_stream_state_t;

endpackage : convolutor_pkg
`default_nettype wire

// File: rtl/convolutor_simple_ram_p.sv
`default_nettype none
// ============================================================================
// Module      : convolutor_simple_ram_p
// Description : Simple dual-port RAM, one synchronous write port and one
//               synchronous read port with a 1-cycle read latency. The read
//               data register updates only when rd_en_i is high, so it holds
//               its value otherwise; it is cleared by reset while the array
//               contents are left untouched.
// Ports       : clk, rst_n             - clock, async active-low reset
//               wr_en_i/wr_addr_i/wr_data_i - write port
//               rd_en_i/rd_addr_i      - read request
//               rd_data_o              - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module convolutor_simple_ram_p #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64,
   parameter int ADDRW = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [ADDRW-1:0] wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [ADDRW-1:0] rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   // Storage array has no reset so it maps onto block/distributed RAM.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         r_mem[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
      end else if (rd_en_i) begin
         r_rd_data <= r_mem[rd_addr_i];
      end
   end

   assign rd_data_o = r_rd_data;

endmodule : convolutor_simple_ram_p
`default_nettype wire

// File: rtl/convolutor_z_streamer.sv
`default_nettype none
// ============================================================================
// Module      : convolutor_z_streamer
// Description : Captures every Z word written by the convolutor into a
//               private buffer and, on conv_done_i, streams the stored words
//               out in address order over a valid/ready interface.
// Ports       : writeZ_i/memZ_addr_i/dataZ_i - Z write port from convolutor
//               conv_done_i                   - job complete pulse
//               m_data_o/m_index_o/m_valid_o/m_ready_i/m_last_o - stream out
//               result_count_o  - highest written address + 1
//               stream_busy_o   - collecting or streaming
//               stream_done_o   - pulse after the last word is accepted
//               overrun_o       - sticky: write arrived while streaming
// Revision    : 1.0 - initial release
// ============================================================================
module convolutor_z_streamer
   import convolutor_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    writeZ_i,
   input  logic [ADDR_WIDTH:0]     memZ_addr_i,
   input  logic [2*DATA_WIDTH-1:0] dataZ_i,
   input  logic                    conv_done_i,
   output logic [2*DATA_WIDTH-1:0] m_data_o,
   output logic [ADDR_WIDTH:0]     m_index_o,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic                    m_last_o,
   output logic [ADDR_WIDTH+1:0]   result_count_o,
   output logic                    stream_busy_o,
   output logic                    stream_done_o,
   output logic                    overrun_o
);

   localparam int ZA_W  = ADDR_WIDTH + 1;
   localparam int ZD_W  = 2 * DATA_WIDTH;
   localparam int Z_DEP = 2 ** ZA_W;

   z_stream_state_t r_state;
   z_stream_state_t w_next_state;

   logic [ZA_W-1:0] r_rd_ptr;
   logic [ZA_W:0]   r_result_count;
   logic [ZA_W-1:0] r_m_index;
   logic            r_m_valid;
   logic            r_m_last;
   logic            r_busy;
   logic            r_stream_done;
   logic            r_overrun;

   logic            w_collecting;
   logic            w_streaming;
   logic            w_handshake;
   logic            w_wr_en;
   logic            w_rd_en;
   logic [ZA_W-1:0] w_rd_addr;
   logic [ZA_W:0]   w_addr_plus1;
   logic            w_rd_is_last;
   logic [ZD_W-1:0] w_rd_data;

   assign w_collecting = (r_state == IDLE) || (r_state == COLLECT);
   assign w_streaming  = (r_state == FETCH) || (r_state == STREAM);
   assign w_handshake  = (r_state == STREAM) && r_m_valid && m_ready_i;

   // Writes are only accepted while a job is being gathered; the buffer is
   // frozen once streaming starts so the outgoing data stays consistent.
   assign w_wr_en      = writeZ_i && w_collecting;
   assign w_addr_plus1 = {1'b0, memZ_addr_i} + (ZA_W+1)'(1);

   // The read port is the output data register: FETCH loads word 0, and each
   // non-final handshake loads the next word so back-to-back beats have no
   // bubble. Without a read the register holds, keeping data stable under
   // backpressure.
   assign w_rd_en      = (r_state == FETCH) || (w_handshake && !r_m_last);
   assign w_rd_addr    = (r_state == FETCH) ? r_rd_ptr : (r_rd_ptr + ZA_W'(1));
   assign w_rd_is_last = ({1'b0, w_rd_addr} == (r_result_count - (ZA_W+1)'(1)));

   convolutor_simple_ram_p #(
      .WIDTH (ZD_W),
      .DEPTH (Z_DEP),
      .ADDRW (ZA_W)
   ) u_zbuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (w_wr_en),
      .wr_addr_i (memZ_addr_i),
      .wr_data_i (dataZ_i),
      .rd_en_i   (w_rd_en),
      .rd_addr_i (w_rd_addr),
      .rd_data_o (w_rd_data)
   );

   // ------------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            // A write together with done is a one-word job: store, then fetch.
            if (writeZ_i) begin
               w_next_state = conv_done_i ? FETCH : COLLECT;
            end
         end
         COLLECT: begin
            if (conv_done_i) begin
               w_next_state = FETCH;
            end
         end
         FETCH: begin
            w_next_state = STREAM;
         end
         STREAM: begin
            if (w_handshake && r_m_last) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Job bookkeeping and stream control
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr       <= '0;
         r_result_count <= '0;
         r_m_index      <= '0;
         r_m_valid      <= 1'b0;
         r_m_last       <= 1'b0;
         r_busy         <= 1'b0;
         r_stream_done  <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         r_stream_done <= 1'b0;
         r_busy        <= (w_next_state != IDLE);

         if (r_state == IDLE) begin
            if (writeZ_i) begin
               r_result_count <= w_addr_plus1;
               r_overrun      <= 1'b0;
            end else if (conv_done_i) begin
               // Empty job: report completion with nothing to stream.
               r_result_count <= '0;
               r_stream_done  <= 1'b1;
            end
         end else if (r_state == COLLECT) begin
            if (writeZ_i && (w_addr_plus1 > r_result_count)) begin
               r_result_count <= w_addr_plus1;
            end
         end

         if (writeZ_i && w_streaming) begin
            r_overrun <= 1'b1;
         end

         if (w_next_state == FETCH && r_state != FETCH) begin
            r_rd_ptr <= '0;
         end

         if (w_rd_en) begin
            r_m_index <= w_rd_addr;
            r_m_last  <= w_rd_is_last;
            r_m_valid <= 1'b1;
            if (r_state == STREAM) begin
               r_rd_ptr <= w_rd_addr;
            end
         end else if (w_handshake && r_m_last) begin
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_stream_done <= 1'b1;
         end
      end
   end

   assign m_data_o       = w_rd_data;
   assign m_index_o      = r_m_index;
   assign m_valid_o      = r_m_valid;
   assign m_last_o       = r_m_last;
   assign result_count_o = r_result_count;
   assign stream_busy_o  = r_busy;
   assign stream_done_o  = r_stream_done;
   assign overrun_o      = r_overrun;

endmodule : convolutor_z_streamer
`default_nettype wire

// File: doc/convolutor_z_streamer.md
# convolutor_z_streamer

Downstream stage of the convolution coprocessor: captures every Z word the convolutor writes (`writeZ`/`memZ_addr`/`dataZ`) into a private dual-port buffer. When the convolutor signals `done`, it streams the stored results out, in address order, over a valid/ready interface. It decouples the convolutor's write-as-you-compute timing from a consumer that can apply backpressure.

## Interface
Parameters:
- `ADDR_WIDTH`, default 5: Y address width. Z address width is `ADDR_WIDTH+1`; buffer depth is `2**(ADDR_WIDTH+1)` (64).
- `DATA_WIDTH`, default 8: sample width. Z word width is `2*DATA_WIDTH` (16).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `writeZ_i`, input, 1: Z write strobe from the convolutor.
- `memZ_addr_i`, input, `ADDR_WIDTH+1`: Z write address.
- `dataZ_i`, input, `2*DATA_WIDTH`: Z write data.
- `conv_done_i`, input, 1: convolutor done pulse.
- `m_data_o`, output, `2*DATA_WIDTH`: streamed Z word.
- `m_index_o`, output, `ADDR_WIDTH+1`: Z address of `m_data_o`.
- `m_valid_o`, output, 1: stream word valid.
- `m_ready_i`, input, 1: consumer ready.
- `m_last_o`, output, 1: current word is the final word of the job.
- `result_count_o`, output, `ADDR_WIDTH+2`: number of words in the job (highest written address + 1).
- `stream_busy_o`, output, 1: collecting or streaming.
- `stream_done_o`, output, 1: one-cycle pulse after the last word is accepted.
- `overrun_o`, output, 1: sticky flag, set when a write arrives while streaming.

## Operation
- States: `IDLE`, `COLLECT`, `FETCH`, `STREAM`.
- **IDLE**
  - A `writeZ_i` clears `result_count`, clears `overrun_o`, stores the word and enters `COLLECT`.
  - `conv_done_i` with no prior write:
    - stays in `IDLE`;
    - pulses `stream_done_o`;
    - `result_count_o` = 0;
    - no beats are produced.
- **COLLECT**
  - Each `writeZ_i` writes `dataZ_i` at `memZ_addr_i`.
  - `result_count` = max(`result_count`, `memZ_addr_i`+1).
  - Rewriting an address overwrites the stored word (last value wins).
  - Addresses never written in the current job read back undefined content.
  - `conv_done_i` moves to `FETCH`, with `rd_ptr`=0.
  - If `writeZ_i` and `conv_done_i` assert in the same cycle, the write is stored and counted first.
- **FETCH**
  - Issues a synchronous read at `rd_ptr`.
  - Next cycle: data is loaded into the output register, `m_valid_o`=1, state `STREAM`.
- **STREAM**
  - `m_data_o`, `m_index_o` and `m_last_o` stay stable while `m_valid_o`=1 and `m_ready_i`=0.
  - On handshake (`m_valid_o & m_ready_i`) with more words remaining: the read for `rd_ptr+1` is issued in the same cycle, so the next word is valid the following cycle (no bubble).
  - `m_last_o` = (`m_index_o` == `result_count`-1).
  - On the last handshake: `m_valid_o` drops next cycle, `stream_done_o` pulses next cycle, state returns to `IDLE`.
- **Overrun**: `writeZ_i` in `FETCH`/`STREAM` is ignored (the buffer is not written) and sets `overrun_o`. `conv_done_i` in `FETCH`/`STREAM` is ignored.
- **`stream_busy_o`** = state ≠ `IDLE`.
- **Reset** (any time, including mid-stream):
  - state = `IDLE`;
  - all outputs are 0 (`m_data_o`, `m_index_o`, `m_valid_o`, `m_last_o`, `result_count_o`, `stream_busy_o`, `stream_done_o`, `overrun_o`);
  - buffer contents are not cleared.
- **Width rules**: `result_count` needs `ADDR_WIDTH+2` bits to hold 64. `rd_ptr` never exceeds `result_count`-1, so there is no wrap.

## Timing
- Write to buffer: stored at the clock edge where `writeZ_i`=1. Readable from the next cycle.
- `conv_done_i` at edge N: `FETCH` during cycle N+1; `m_valid_o`=1 from edge N+2.
- Throughput: 1 word/cycle while `m_ready_i`=1.
- A job of K words with `m_ready_i` held high takes K cycles of `m_valid_o`. `stream_done_o` is asserted in the cycle after the last handshake.
- All outputs are registered; there is no combinational path from `m_ready_i` to `m_valid_o`.

## Structure
- Shared package `convolutor_pkg`:
  - `typedef enum logic [1:0] {IDLE, COLLECT, FETCH, STREAM} z_stream_state_t`;
  - `localparam Z_ADDR_WIDTH = ADDR_WIDTH+1`, `Z_DATA_WIDTH = 2*DATA_WIDTH`, `Z_DEPTH = 2**Z_ADDR_WIDTH`.
- Sub-module `convolutor_simple_ram_p`:
  - one synchronous write port, one synchronous read port, 1-cycle read latency;
  - parameterised `WIDTH`, `DEPTH`, `ADDRW`.
- Top-level holds the FSM, `rd_ptr`, `result_count`, the output register and flags.

## Test plan
- **Basic 7-word job**: write addr 0..6 with data 0x0010..0x0016, `conv_done_i`, `m_ready_i`=1.
  - Expect 7 consecutive beats with data 0x0010..0x0016 and index 0..6.
  - `m_last_o` asserted only on index 6.
  - `stream_done_o` one cycle after the last beat; `result_count_o`=7.
- **Backpressure**: same job with `m_ready_i` toggling 1,0,0,1,…
  - Data and index hold while not ready.
  - Every word delivered exactly once, in order, no gaps in index.
- **Out-of-order and overwrite**: write addr 3=0x00AA, then 0=0x0001, then 3=0x00BB, then done.
  - `result_count_o`=4; index 0 = 0x0001; index 3 = 0x00BB.
- **Empty job and simultaneous events**:
  - `conv_done_i` in `IDLE` with no writes: `stream_done_o` pulse, no `m_valid_o`.
  - `writeZ_i` to addr 5 in the same cycle as `conv_done_i`: count = 6.
- **Overrun**: `writeZ_i` to addr 0 with 0xFFFF while streaming.
  - `overrun_o`=1; streamed index 0 keeps its original value.
  - `overrun_o` clears on the next job's first write.
- **Reset mid-stream**: assert `rst_n`=0 at beat 3 of 7.
  - All outputs go to 0 immediately.
  - A subsequent full job streams correctly.
